// File: rtl/tri_count_monitor.sv
// tri_count_monitor: receive-side checker for an up/down triangle counter.
// Acquires lock on the sample sequence, recovers the count direction, flags
// peaks/troughs, counts completed triangles and counts sequence errors.
//
// Ports:
//   clock        in   rising-edge clock
//   clear        in   synchronous active-high reset, highest priority
//   sample_valid in   sample is presented this cycle
//   sample       in   counter value (WIDTH)
//   locked       out  sequence acquired
//   dir          out  0 = up, 1 = down (0 when not locked)
//   peak         out  pulse: matched sample == MAX
//   trough       out  pulse: matched sample == 0
//   err          out  pulse: mismatch while locked
//   lost         out  pulse: lock dropped after ERR_LIMIT consecutive misses
//   err_count    out  saturating mismatch count (8 bits)
//   cycles       out  completed triangles, wrapping (CYC_W bits)
module tri_count_monitor #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned ERR_LIMIT = 3,
  parameter int unsigned CYC_W     = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] sample,
  output logic             locked,
  output logic             dir,
  output logic             peak,
  output logic             trough,
  output logic             err,
  output logic             lost,
  output logic [7:0]       err_count,
  output logic [CYC_W-1:0] cycles
);

  localparam int unsigned MISS_W = $clog2(ERR_LIMIT + 1);
  localparam int unsigned EXT_W  = WIDTH + 1;
  localparam logic [WIDTH-1:0] MAX_V  = '1;
  localparam logic [WIDTH-1:0] ZERO_V = '0;

  typedef enum logic [1:0] {
    S_EMPTY  = 2'd0,
    S_ONE    = 2'd1,
    S_LOCKED = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    last_q, last_d;
  logic [MISS_W-1:0]   miss_q, miss_d;
  logic                locked_q, locked_d;
  logic                dir_q, dir_d;
  logic                peak_q, peak_d;
  logic                trough_q, trough_d;
  logic                err_q, err_d;
  logic                lost_q, lost_d;
  logic [7:0]          err_count_q, err_count_d;
  logic [CYC_W-1:0]    cycles_q, cycles_d;

  // Neighbour tests done one bit wider so MAX+1 / 0-1 never alias a real value.
  logic [EXT_W-1:0]    last_ext, sample_ext;
  logic                step_up, step_dn;
  logic [WIDTH-1:0]    expect_v;
  logic [MISS_W-1:0]   miss_inc;

  assign last_ext   = {1'b0, last_q};
  assign sample_ext = {1'b0, sample};
  assign step_up    = (sample_ext == last_ext + EXT_W'(1));
  assign step_dn    = (sample_ext + EXT_W'(1) == last_ext);
  assign miss_inc   = miss_q + MISS_W'(1);

  // Predicted next value of the triangle while locked.
  always_comb begin
    expect_v = ZERO_V;
    if (last_q == MAX_V)       expect_v = MAX_V - WIDTH'(1);
    else if (last_q == ZERO_V) expect_v = WIDTH'(1);
    else if (dir_q)            expect_v = last_q - WIDTH'(1);
    else                       expect_v = last_q + WIDTH'(1);
  end

  // State register and registered outputs.
  always_ff @(posedge clock) begin
    state_q     <= state_d;
    last_q      <= last_d;
    miss_q      <= miss_d;
    locked_q    <= locked_d;
    dir_q       <= dir_d;
    peak_q      <= peak_d;
    trough_q    <= trough_d;
    err_q       <= err_d;
    lost_q      <= lost_d;
    err_count_q <= err_count_d;
    cycles_q    <= cycles_d;
  end

  // Next-state and output logic; clear folded in so it overrides everything.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    miss_d      = miss_q;
    dir_d       = dir_q;
    peak_d      = 1'b0;
    trough_d    = 1'b0;
    err_d       = 1'b0;
    lost_d      = 1'b0;
    err_count_d = err_count_q;
    cycles_d    = cycles_q;

    if (clear) begin
      state_d     = S_EMPTY;
      last_d      = ZERO_V;
      miss_d      = '0;
      dir_d       = 1'b0;
      err_count_d = '0;
      cycles_d    = '0;
    end else if (sample_valid) begin
      unique case (state_q)
        S_EMPTY: begin
          last_d = sample;
          if (sample == ZERO_V) begin
            state_d = S_LOCKED;
            dir_d   = 1'b0;
          end else if (sample == MAX_V) begin
            state_d = S_LOCKED;
            dir_d   = 1'b1;
          end else begin
            state_d = S_ONE;
          end
        end
        S_ONE: begin
          last_d = sample;
          if (step_up || step_dn) begin
            state_d = S_LOCKED;
            // Endpoints fix the direction regardless of the approach.
            if (sample == MAX_V)       dir_d = 1'b1;
            else if (sample == ZERO_V) dir_d = 1'b0;
            else                       dir_d = step_dn;
          end
        end
        S_LOCKED: begin
          // Prediction free-runs on the expected value whether or not it matched.
          last_d = expect_v;
          if (expect_v == MAX_V)       dir_d = 1'b1;
          else if (expect_v == ZERO_V) dir_d = 1'b0;
          if (sample == expect_v) begin
            miss_d = '0;
            if (sample == MAX_V) peak_d = 1'b1;
            if (sample == ZERO_V) begin
              trough_d = 1'b1;
              cycles_d = cycles_q + CYC_W'(1);
            end
          end else begin
            err_d = 1'b1;
            if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
            if (miss_inc == MISS_W'(ERR_LIMIT)) begin
              lost_d  = 1'b1;
              miss_d  = '0;
              state_d = S_EMPTY;
              dir_d   = 1'b0;
            end else begin
              miss_d = miss_inc;
            end
          end
        end
        default: begin
          state_d = S_EMPTY;
          dir_d   = 1'b0;
        end
      endcase
    end

    locked_d = (state_d == S_LOCKED);
  end

  assign locked    = locked_q;
  assign dir       = dir_q;
  assign peak      = peak_q;
  assign trough    = trough_q;
  assign err       = err_q;
  assign lost      = lost_q;
  assign err_count = err_count_q;
  assign cycles    = cycles_q;

endmodule

// File: tb/tb_tri_count_monitor.sv
module tb_tri_count_monitor;

  localparam int MAXV  = 15;
  localparam int LIMIT = 3;

  logic        clock;
  logic        clear;
  logic        sample_valid;
  logic [3:0]  sample;
  logic        locked, dir, peak, trough, err, lost;
  logic [7:0]  err_count;
  logic [15:0] cycles;

  int total = 0;
  int bad   = 0;

  // Expected output word: {locked,dir,peak,trough,err,lost,err_count,cycles}
  logic [29:0] exp_q[$];

  // Reference model state (plain integers)
  int m_state = 0;   // 0 empty, 1 one sample seen, 2 locked
  int m_last  = 0;
  int m_dir   = 0;
  int m_miss  = 0;
  int m_errc  = 0;
  int m_cyc   = 0;
  int p_peak, p_trough, p_err, p_lost;

  tri_count_monitor dut (
    .clock        (clock),
    .clear        (clear),
    .sample_valid (sample_valid),
    .sample       (sample),
    .locked       (locked),
    .dir          (dir),
    .peak         (peak),
    .trough       (trough),
    .err          (err),
    .lost         (lost),
    .err_count    (err_count),
    .cycles       (cycles)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic int predict(input int last, input int d);
    if (last == MAXV) return MAXV - 1;
    if (last == 0)    return 1;
    return d ? last - 1 : last + 1;
  endfunction

  task automatic model_step(input bit c, input bit v, input int s);
    int e;
    p_peak = 0; p_trough = 0; p_err = 0; p_lost = 0;
    if (c) begin
      m_state = 0; m_last = 0; m_dir = 0; m_miss = 0; m_errc = 0; m_cyc = 0;
    end else if (v) begin
      if (m_state == 0) begin
        m_last = s;
        if (s == 0)         begin m_state = 2; m_dir = 0; end
        else if (s == MAXV) begin m_state = 2; m_dir = 1; end
        else                m_state = 1;
      end else if (m_state == 1) begin
        if (s == m_last + 1 || s == m_last - 1) begin
          m_state = 2;
          m_dir = (s == m_last - 1) ? 1 : 0;
          if (s == MAXV) m_dir = 1;
          if (s == 0)    m_dir = 0;
        end
        m_last = s;
      end else begin
        e = predict(m_last, m_dir);
        m_last = e;
        if (e == MAXV) m_dir = 1;
        if (e == 0)    m_dir = 0;
        if (s == e) begin
          m_miss = 0;
          if (s == MAXV) p_peak = 1;
          if (s == 0) begin
            p_trough = 1;
            m_cyc = (m_cyc + 1) % 65536;
          end
        end else begin
          p_err = 1;
          if (m_errc < 255) m_errc++;
          m_miss++;
          if (m_miss == LIMIT) begin
            p_lost = 1; m_miss = 0; m_state = 0; m_dir = 0;
          end
        end
      end
    end
  endtask

  function automatic logic [29:0] model_out();
    return {(m_state == 2), 1'(m_dir), 1'(p_peak), 1'(p_trough), 1'(p_err),
            1'(p_lost), 8'(m_errc), 16'(m_cyc)};
  endfunction

  // Driver: inputs change on the falling edge; expected response queued.
  task automatic drive(input bit c, input bit v, input int s);
    @(negedge clock);
    clear        = c;
    sample_valid = v;
    sample       = 4'(s);
    model_step(c, v, s);
    exp_q.push_back(model_out());
  endtask

  task automatic run_up(input int a, input int b);
    for (int i = a; i <= b; i++) drive(0, 1, i);
  endtask

  task automatic run_dn(input int a, input int b);
    for (int i = a; i >= b; i--) drive(0, 1, i);
  endtask

  // Monitor: the DUT presents an output word every cycle; compare against queue.
  initial begin
    logic [29:0] want, got;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        got  = {locked, dir, peak, trough, err, lost, err_count, cycles};
        total++;
        if (got !== want) begin
          bad++;
          $display("FAIL outputs t=%0t got lk=%b dr=%b pk=%b tr=%b er=%b ls=%b ec=%0d cy=%0d want lk=%b dr=%b pk=%b tr=%b er=%b ls=%b ec=%0d cy=%0d",
                   $time, got[29], got[28], got[27], got[26], got[25], got[24], got[23:16], got[15:0],
                   want[29], want[28], want[27], want[26], want[25], want[24], want[23:16], want[15:0]);
        end
      end
    end
  end

  initial begin
    int cval, cup, s, v, c;
    clear = 1'b1; sample_valid = 1'b0; sample = 4'd0;

    // Full triangle from reset
    drive(1, 0, 0);
    run_up(0, 15); run_dn(14, 0); drive(0, 1, 1);
    drive(0, 0, 0);

    // Two-sample acquisition: up, down, and non-neighbour
    drive(1, 0, 0); drive(0, 1, 7); drive(0, 1, 8); drive(0, 0, 0);
    drive(1, 0, 0); drive(0, 1, 9); drive(0, 1, 8); drive(0, 0, 0);
    drive(1, 0, 0); drive(0, 1, 3); drive(0, 1, 9); drive(0, 0, 0);

    // Single glitch while descending
    drive(1, 0, 0); drive(0, 1, 10); drive(0, 1, 9); drive(0, 1, 5);
    drive(0, 1, 7); drive(0, 1, 6); drive(0, 0, 0);

    // Three consecutive misses drop lock, then relock on 0
    drive(1, 0, 0); drive(0, 1, 3); drive(0, 1, 4);
    drive(0, 1, 12); drive(0, 1, 12); drive(0, 1, 12);
    drive(0, 1, 0); drive(0, 0, 0);

    // Gaps around the peak
    drive(1, 0, 0); run_up(12, 13);
    drive(0, 1, 14); drive(0, 0, 3); drive(0, 0, 9); drive(0, 1, 15);
    drive(0, 0, 0); drive(0, 1, 14); drive(0, 0, 0);

    // Two triangles, one glitch, then clear with a valid 0
    drive(1, 0, 0);
    run_up(0, 15); run_dn(14, 0); run_up(1, 15); run_dn(14, 0);
    drive(0, 1, 9); drive(0, 1, 2);
    drive(1, 1, 0); drive(0, 0, 0); drive(0, 1, 5);

    // Randomized triangle stream with gaps, corruption and rare clears
    cval = $urandom_range(0, 15);
    cup  = $urandom_range(0, 1);
    for (int n = 0; n < 3000; n++) begin
      c = ($urandom_range(0, 299) == 0) ? 1 : 0;
      v = ($urandom_range(0, 3) != 0) ? 1 : 0;
      s = cval;
      if ($urandom_range(0, 11) == 0) s = $urandom_range(0, 15);
      if ($urandom_range(0, 399) == 0) begin
        // occasional burst of junk to force loss of lock
        for (int k = 0; k < 4; k++) drive(0, 1, $urandom_range(0, 15));
      end
      drive(c, v, s);
      if (v) begin
        if (cval == MAXV) cup = 0;
        else if (cval == 0) cup = 1;
        cval = cup ? cval + 1 : cval - 1;
      end
    end

    drive(0, 0, 0);
    @(posedge clock);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d pending want=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
